xif_mac_coproc: RTL and testbench
=================================

Name: xif_mac_coproc

Overview:
- CORE-V-XIF coprocessor: the responder on the issue, commit and result channels driven by the CV32E20 CPU subsystem.
- Decodes a small custom-0 instruction set and buffers accepted instructions in order until they commit.
- Executes committed instructions on a 32-bit multiply-accumulate datapath and returns register writebacks on the result channel.
- Sits beside the CPU subsystem in core_v_mini_mcu, attached to the same X-interface instance.

Parameters:
- DEPTH, 4, number of accepted-but-not-retired entries (power of two, ≥2).
- MUL_LATENCY, 2, EXEC cycles per instruction (≥1).
- X_ID_WIDTH, 4, width of the instruction id.
- OPCODE, 7'b0001011, major opcode claimed (custom-0).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- issue_valid_i  in  1  CPU offers an instruction.
- issue_ready_o  out  1  = !fifo_full.
- issue_instr_i  in  32  instruction word.
- issue_rs1_i  in  32  source operand 1.
- issue_rs2_i  in  32  source operand 2.
- issue_rs_valid_i  in  2  operand valid bits.
- issue_id_i  in  X_ID_WIDTH  instruction id.
- issue_accept_o  out  1  instruction claimed; valid while issue_valid_i=1.
- issue_writeback_o  out  1  will write rd; equals issue_accept_o.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  X_ID_WIDTH  id being committed.
- commit_kill_i  in  1  1 = discard instruction.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  CPU takes result.
- result_id_o  out  X_ID_WIDTH  id of result.
- result_rd_o  out  5  destination register.
- result_data_o  out  32  writeback value.
- result_we_o  out  1  always 1 while result_valid_o=1.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Decode (combinational): hit = opcode==OPCODE && funct3∈{000,001,010} && rs_valid==2'b11.
  - 000 MAC: acc += rs1*rs2 (signed, low 32 bits of the product); rd = new acc.
  - 001 RDCLR: rd = acc; acc = 0.
  - 010 ADD: rd = rs1+rs2; acc unchanged.
- Enqueue: on issue_valid_i && issue_ready_o && hit, push {id, funct3, rd, rs1, rs2, committed=0, killed=0}.
  - Non-hit instructions complete the handshake with accept=0 and are not stored.
- Commit: marks the FIFO entry whose id matches as committed or killed.
  - Commit in the same cycle as that id's issue handshake applies to the entry being pushed.
  - Unmatched ids are ignored.
- FSM IDLE / EXEC / RESP:
  - IDLE: head committed and not killed → pop to the working register, go to EXEC with cnt=0. Head killed → pop, stay IDLE, no result.
  - EXEC: cnt increments each cycle. On cnt==MUL_LATENCY-1: compute rd value, update acc, go to RESP.
  - RESP: result_valid_o=1 with outputs held stable until result_ready_i. On handshake go to IDLE; a new head may be popped the next cycle.
- Latency: an instruction committed at cycle C with an empty pipeline shows result_valid_o at C+1+MUL_LATENCY+1.
- Push and pop may occur in the same cycle. A full FIFO accepts a push only while issue_ready_o is high, i.e. not in the cycle a pop frees a slot (no combinational ready path from pop).
- Pointers wrap modulo DEPTH; full/empty are tracked with an extra pointer bit.
- Reset: all outputs 0, FIFO empty, acc=0, FSM IDLE. Reset asserted mid-EXEC or mid-RESP drops all entries without producing a result.

Optional Feature:
- Macro COPROC_MAC_SAT_EN.
- Defined: MAC saturates acc at +2^31-1 / -2^31, using a 64-bit signed sum clamped to 32 bits.
- Undefined: MAC wraps modulo 2^32.
- ADD always wraps in both builds.

Decomposition:
- Package xif_mac_coproc_pkg: OPCODE default, funct3 enum (F3_MAC, F3_RDCLR, F3_ADD), entry_t struct, fsm enum (IDLE, EXEC, RESP).
- One sub-module: xif_mac_coproc_fifo. Parameterised by DEPTH; owns the id-matched commit/kill flag update; exposes head entry, full, empty, pop.

Test Plan:
- Reject: issue instr opcode 0110011 → handshake completes, accept=0, writeback=0, busy_o stays 0, no result.
- MAC: acc=0; issue MAC rs1=3 rs2=5 id=2, commit id=2 → exactly MUL_LATENCY+2 cycles after commit, result id=2, data=15. Second MAC rs1=-2 rs2=4 → data=7.
- Kill ordering: issue id=1 ADD(1,1), id=2 ADD(2,2), then commit id=1 kill=1 and commit id=2 kill=0 → only one result: id=2, data=4.
- Backpressure: fill DEPTH entries → issue_ready_o=0. Hold result_ready_i=0 for 10 cycles → result outputs stable. Release → entries drain in order.
- Saturation: acc=0x7FFFFFF0, MAC 16*1 → with COPROC_MAC_SAT_EN data=0x7FFFFFFF, without it data=0x80000000. Then RDCLR returns that value and a following RDCLR returns 0.
- Reset mid-EXEC: assert rst_ni=0 for one edge → result_valid_o=0 and busy_o=0 next cycle. A new MAC 2*2 returns 4.

Source files
------------

// File: rtl/xif_mac_coproc_pkg.sv
// xif_mac_coproc_pkg: shared types for the XIF multiply-accumulate coprocessor.
// Holds the default custom-0 opcode, the funct3 and FSM encodings, and the FIFO entry layout.
package xif_mac_coproc_pkg;

   localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

   typedef enum logic [2:0] {
      F3_MAC   = 3'b000,
      F3_RDCLR = 3'b001,
      F3_ADD   = 3'b010
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } fsm_e;

   // Payload of one buffered instruction; id and status flags live beside it in the FIFO
   typedef struct packed {
      funct3_e     funct3;
      logic [4:0]  rd;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } entry_t;

   function automatic logic is_hit_f3(input logic [2:0] f3);
      return (f3 == F3_MAC) || (f3 == F3_RDCLR) || (f3 == F3_ADD);
   endfunction

endpackage

// File: rtl/xif_mac_coproc_fifo.sv
// xif_mac_coproc_fifo: in-order buffer of accepted instructions awaiting commit.
// Ports: push_i/push_entry_i/push_id_i enqueue, pop_i dequeues the head,
// commit_valid_i/commit_id_i/commit_kill_i mark a matching entry, head_* expose the
// oldest entry, full_o/empty_o report occupancy.
module xif_mac_coproc_fifo
   import xif_mac_coproc_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned X_ID_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  entry_t                push_entry_i,
   input  logic [X_ID_WIDTH-1:0] push_id_i,
   input  logic                  pop_i,
   input  logic                  commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] commit_id_i,
   input  logic                  commit_kill_i,
   output entry_t                head_o,
   output logic [X_ID_WIDTH-1:0] head_id_o,
   output logic                  head_committed_o,
   output logic                  head_killed_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty
   logic [AW:0]           wr_q, wr_d;
   logic [AW:0]           rd_q, rd_d;
   logic [AW-1:0]         wr_idx, rd_idx;
   entry_t                mem_q [DEPTH];
   logic [X_ID_WIDTH-1:0] id_q  [DEPTH];
   logic [DEPTH-1:0]      vld_q, vld_d;
   logic [DEPTH-1:0]      cmt_q, cmt_d;
   logic [DEPTH-1:0]      kill_q, kill_d;
   logic                  push_match;

   assign wr_idx = wr_q[AW-1:0];
   assign rd_idx = rd_q[AW-1:0];

   // A commit for the id being pushed this cycle lands on the new entry
   assign push_match = commit_valid_i && (commit_id_i == push_id_i);

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      vld_d  = vld_q;
      cmt_d  = cmt_q;
      kill_d = kill_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (commit_valid_i && vld_q[i] && (id_q[i] == commit_id_i)) begin
            cmt_d[i]  = 1'b1;
            kill_d[i] = commit_kill_i;
         end
      end
      if (pop_i) begin
         vld_d[rd_idx] = 1'b0;
         rd_d          = rd_q + 1'b1;
      end
      if (push_i) begin
         vld_d[wr_idx]  = 1'b1;
         cmt_d[wr_idx]  = push_match;
         kill_d[wr_idx] = push_match && commit_kill_i;
         wr_d           = wr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q   <= '0;
         rd_q   <= '0;
         vld_q  <= '0;
         cmt_q  <= '0;
         kill_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         vld_q  <= vld_d;
         cmt_q  <= cmt_d;
         kill_q <= kill_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by vld_q
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_idx] <= push_entry_i;
         id_q[wr_idx]  <= push_id_i;
      end
   end

   assign head_o           = mem_q[rd_idx];
   assign head_id_o        = id_q[rd_idx];
   assign head_committed_o = cmt_q[rd_idx];
   assign head_killed_o    = kill_q[rd_idx];
   assign empty_o          = (wr_q == rd_q);
   assign full_o           = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);

endmodule

// File: rtl/xif_mac_coproc.sv
// xif_mac_coproc: CORE-V-XIF coprocessor with a 32-bit multiply-accumulate datapath.
// Ports: issue_* (decode/accept), commit_* (commit or kill by id), result_* (writeback
// handshake), busy_o. Build macro COPROC_MAC_SAT_EN makes MAC saturate instead of wrap.
module xif_mac_coproc
   import xif_mac_coproc_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned X_ID_WIDTH  = 4,
   parameter logic [6:0]  OPCODE      = OPCODE_CUSTOM0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [31:0]           issue_rs1_i,
   input  logic [31:0]           issue_rs2_i,
   input  logic [1:0]            issue_rs_valid_i,
   input  logic [X_ID_WIDTH-1:0] issue_id_i,
   output logic                  issue_accept_o,
   output logic                  issue_writeback_o,
   input  logic                  commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] commit_id_i,
   input  logic                  commit_kill_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [X_ID_WIDTH-1:0] result_id_o,
   output logic [4:0]            result_rd_o,
   output logic [31:0]           result_data_o,
   output logic                  result_we_o,
   output logic                  busy_o
);

   localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   logic                  hit;
   logic                  push;
   logic                  pop;
   logic [2:0]            f3;
   entry_t                push_entry;
   entry_t                head;
   logic [X_ID_WIDTH-1:0] head_id;
   logic                  head_cmt;
   logic                  head_kill;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  unused_instr;

   fsm_e                  state_q;
   logic [CW-1:0]         cnt_q;
   entry_t                work_q;
   logic [X_ID_WIDTH-1:0] work_id_q;
   logic [31:0]           acc_q, acc_d;
   logic [31:0]           res_d;
   logic [31:0]           prod_lo;
   logic                  rvalid_q;
   logic [X_ID_WIDTH-1:0] rid_q;
   logic [4:0]            rrd_q;
   logic [31:0]           rdata_q;
`ifdef COPROC_MAC_SAT_EN
   logic signed [63:0]    sat_sum;
`endif

   assign f3           = issue_instr_i[14:12];
   assign unused_instr = ^issue_instr_i[31:15];

   assign hit = (issue_instr_i[6:0] == OPCODE)
             && is_hit_f3(f3)
             && (issue_rs_valid_i == 2'b11);

   // Gated by rst_ni so every output reads 0 while reset is held
   assign issue_ready_o     = rst_ni && !fifo_full;
   assign issue_accept_o    = rst_ni && issue_valid_i && hit;
   assign issue_writeback_o = issue_accept_o;

   assign push = issue_valid_i && issue_ready_o && hit;

   assign push_entry = '{
      funct3: funct3_e'(f3),
      rd:     issue_instr_i[11:7],
      rs1:    issue_rs1_i,
      rs2:    issue_rs2_i
   };

   // Killed heads are popped too, they just never reach EXEC
   assign pop = (state_q == IDLE) && !fifo_empty && head_cmt;

   xif_mac_coproc_fifo #(
      .DEPTH      (DEPTH),
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_fifo (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .push_i           (push),
      .push_entry_i     (push_entry),
      .push_id_i        (issue_id_i),
      .pop_i            (pop),
      .commit_valid_i   (commit_valid_i),
      .commit_id_i      (commit_id_i),
      .commit_kill_i    (commit_kill_i),
      .head_o           (head),
      .head_id_o        (head_id),
      .head_committed_o (head_cmt),
      .head_killed_o    (head_kill),
      .full_o           (fifo_full),
      .empty_o          (fifo_empty)
   );

   // Low 32 product bits are identical for signed and unsigned operands
   assign prod_lo = work_q.rs1 * work_q.rs2;

   always_comb begin
      acc_d = acc_q;
      res_d = acc_q;
`ifdef COPROC_MAC_SAT_EN
      sat_sum = '0;
`endif
      unique case (work_q.funct3)
         F3_MAC: begin
`ifdef COPROC_MAC_SAT_EN
            sat_sum = 64'($signed(acc_q)) + 64'($signed(prod_lo));
            if (sat_sum > 64'sd2147483647) begin
               acc_d = 32'h7FFF_FFFF;
            end else if (sat_sum < -64'sd2147483648) begin
               acc_d = 32'h8000_0000;
            end else begin
               acc_d = sat_sum[31:0];
            end
`else
            acc_d = acc_q + prod_lo;
`endif
            res_d = acc_d;
         end
         F3_RDCLR: begin
            res_d = acc_q;
            acc_d = '0;
         end
         F3_ADD: begin
            res_d = work_q.rs1 + work_q.rs2;
         end
         default: begin
            res_d = acc_q;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         work_id_q <= '0;
         acc_q     <= '0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rrd_q     <= '0;
         rdata_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pop && !head_kill) begin
                  work_q    <= head;
                  work_id_q <= head_id;
                  cnt_q     <= '0;
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q == CW'(MUL_LATENCY - 1)) begin
                  acc_q    <= acc_d;
                  rvalid_q <= 1'b1;
                  rid_q    <= work_id_q;
                  rrd_q    <= work_q.rd;
                  rdata_q  <= res_d;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (result_ready_i) begin
                  rvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign result_valid_o = rvalid_q;
   assign result_id_o    = rid_q;
   assign result_rd_o    = rrd_q;
   assign result_data_o  = rdata_q;
   assign result_we_o    = rvalid_q;
   assign busy_o         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_xif_mac_coproc.sv
// tb_xif_mac_coproc: scoreboard bench for the XIF MAC coprocessor.
// Expected writebacks are queued at commit time and matched on each result handshake.
module tb_xif_mac_coproc;

   localparam int         DEPTH = 4;
   localparam int         ML    = 2;
   localparam int         IDW   = 4;
   localparam logic [6:0] OPC   = 7'b0001011;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           issue_valid_i = 1'b0;
   logic           issue_ready_o;
   logic [31:0]    issue_instr_i = '0;
   logic [31:0]    issue_rs1_i = '0;
   logic [31:0]    issue_rs2_i = '0;
   logic [1:0]     issue_rs_valid_i = '0;
   logic [IDW-1:0] issue_id_i = '0;
   logic           issue_accept_o;
   logic           issue_writeback_o;
   logic           commit_valid_i = 1'b0;
   logic [IDW-1:0] commit_id_i = '0;
   logic           commit_kill_i = 1'b0;
   logic           result_valid_o;
   logic           result_ready_i = 1'b1;
   logic [IDW-1:0] result_id_o;
   logic [4:0]     result_rd_o;
   logic [31:0]    result_data_o;
   logic           result_we_o;
   logic           busy_o;

   typedef struct {
      logic [2:0]     f3;
      logic [4:0]     rd;
      logic [31:0]    a;
      logic [31:0]    b;
      logic [IDW-1:0] id;
   } pend_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [4:0]     rd;
      logic [31:0]    data;
   } exp_t;

   pend_t       pend_q[$];
   exp_t        exp_q[$];
   logic [31:0] acc_m = '0;
   int          errors = 0;
   int          checks = 0;
   int          nres = 0;

   always #5 clk_i = ~clk_i;

   xif_mac_coproc #(
      .DEPTH       (DEPTH),
      .MUL_LATENCY (ML),
      .X_ID_WIDTH  (IDW)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .issue_valid_i     (issue_valid_i),
      .issue_ready_o     (issue_ready_o),
      .issue_instr_i     (issue_instr_i),
      .issue_rs1_i       (issue_rs1_i),
      .issue_rs2_i       (issue_rs2_i),
      .issue_rs_valid_i  (issue_rs_valid_i),
      .issue_id_i        (issue_id_i),
      .issue_accept_o    (issue_accept_o),
      .issue_writeback_o (issue_writeback_o),
      .commit_valid_i    (commit_valid_i),
      .commit_id_i       (commit_id_i),
      .commit_kill_i     (commit_kill_i),
      .result_valid_o    (result_valid_o),
      .result_ready_i    (result_ready_i),
      .result_id_o       (result_id_o),
      .result_rd_o       (result_rd_o),
      .result_data_o     (result_data_o),
      .result_we_o       (result_we_o),
      .busy_o            (busy_o)
   );

   // Scoreboard side: every consumed result is matched against the oldest expectation
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni && result_valid_o && result_ready_i) begin
         nres++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result id=%0d data=%h, required no result",
                     result_id_o, result_data_o);
         end else begin
            e = exp_q.pop_front();
            if (result_id_o !== e.id || result_rd_o !== e.rd ||
                result_data_o !== e.data || result_we_o !== 1'b1) begin
               errors++;
               $display("FAIL result got id=%0d rd=%0d data=%h we=%b, required id=%0d rd=%0d data=%h we=1",
                        result_id_o, result_rd_o, result_data_o, result_we_o,
                        e.id, e.rd, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
      return {17'd0, f3, rd, OPC};
   endfunction

   // Reference model: retire in commit order and queue the expected writeback
   task automatic retire(input logic [IDW-1:0] id, input bit kill);
      int          idx;
      pend_t       p;
      logic [31:0] prod;
      logic [31:0] r;
      exp_t        e;
`ifdef COPROC_MAC_SAT_EN
      longint      s;
`endif
      idx = -1;
      foreach (pend_q[i]) begin
         if (idx < 0 && pend_q[i].id == id) idx = i;
      end
      if (idx < 0) return;
      p = pend_q[idx];
      pend_q.delete(idx);
      if (kill) return;
      prod = p.a * p.b;
      case (p.f3)
         3'b000: begin
`ifdef COPROC_MAC_SAT_EN
            s = longint'($signed(acc_m)) + longint'($signed(prod));
            if (s > 64'sd2147483647) acc_m = 32'h7fffffff;
            else if (s < -64'sd2147483648) acc_m = 32'h80000000;
            else acc_m = s[31:0];
`else
            acc_m = acc_m + prod;
`endif
            r = acc_m;
         end
         3'b001: begin
            r = acc_m;
            acc_m = '0;
         end
         default: r = p.a + p.b;
      endcase
      e.id = id;
      e.rd = p.rd;
      e.data = r;
      exp_q.push_back(e);
   endtask

   task automatic do_issue(input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [IDW-1:0] id, input bit cmt,
                           input bit kill, output logic acc_seen);
      int    n;
      pend_t p;
      n = 0;
      issue_valid_i    = 1'b1;
      issue_instr_i    = enc(f3, rd);
      issue_rs1_i      = a;
      issue_rs2_i      = b;
      issue_rs_valid_i = 2'b11;
      issue_id_i       = id;
      commit_valid_i   = cmt;
      commit_id_i      = id;
      commit_kill_i    = kill;
      #1;
      while (!issue_ready_o && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout id=%0d ready=%b, required 1", id, issue_ready_o);
      end
      acc_seen = issue_accept_o;
      p.f3 = f3;
      p.rd = rd;
      p.a  = a;
      p.b  = b;
      p.id = id;
      pend_q.push_back(p);
      tick();
      issue_valid_i  = 1'b0;
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      if (cmt) retire(id, kill);
   endtask

   task automatic do_commit(input logic [IDW-1:0] id, input bit kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      retire(id, kill);
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 300) begin
         tick();
         n++;
      end
      repeat (3) tick();
      ok = (exp_q.size() == 0) && (busy_o === 1'b0);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) tick();
      checks++;
      if ({result_valid_o, result_we_o, result_id_o, result_rd_o, result_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_result valid=%b data=%h, required all 0", result_valid_o, result_data_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b, required 0", busy_o);
      end
      checks++;
      if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_issue got %b, required 000",
                  {issue_ready_o, issue_accept_o, issue_writeback_o});
      end
      rst_ni = 1'b1;
      tick();
      checks++;
      if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset ready=%b busy=%b, required ready=1 busy=0", issue_ready_o, busy_o);
      end
   endtask

   task automatic test_reject();
      bit bad;
      issue_valid_i    = 1'b1;
      issue_instr_i    = {17'd0, 3'b000, 5'd1, 7'b0110011};
      issue_rs_valid_i = 2'b11;
      issue_id_i       = 4'd3;
      #1;
      checks++;
      if ({issue_accept_o, issue_writeback_o} !== 2'b00) begin
         errors++;
         $display("FAIL reject_opcode accept/wb=%b, required 00", {issue_accept_o, issue_writeback_o});
      end
      checks++;
      if (issue_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reject_ready got %b, required 1", issue_ready_o);
      end
      tick();
      issue_instr_i = enc(3'b011, 5'd1);
      #1;
      checks++;
      if (issue_accept_o !== 1'b0) begin
         errors++;
         $display("FAIL reject_funct3 accept=%b, required 0", issue_accept_o);
      end
      tick();
      issue_instr_i    = enc(3'b000, 5'd1);
      issue_rs_valid_i = 2'b01;
      #1;
      checks++;
      if (issue_accept_o !== 1'b0) begin
         errors++;
         $display("FAIL reject_rsvalid accept=%b, required 0", issue_accept_o);
      end
      tick();
      issue_valid_i = 1'b0;
      bad = 1'b0;
      repeat (6) begin
         tick();
         if (busy_o !== 1'b0 || result_valid_o !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reject_idle busy=%b valid=%b, required 0 0", busy_o, result_valid_o);
      end
   endtask

   task automatic test_mac();
      logic a;
      int   n;
      bit   ok;
      do_issue(3'b000, 5'd5, 32'd3, 32'd5, 4'd2, 1'b0, 1'b0, a);
      checks++;
      if (a !== 1'b1) begin
         errors++;
         $display("FAIL mac_accept got %b, required 1", a);
      end
      do_commit(4'd2, 1'b0);
      n = 1;
      while (!result_valid_o && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (n != ML + 2) begin
         errors++;
         $display("FAIL mac_latency got %0d cycles, required %0d", n, ML + 2);
      end
      checks++;
      if (result_id_o !== 4'd2 || result_data_o !== 32'd15) begin
         errors++;
         $display("FAIL mac_first id=%0d data=%0d, required id=2 data=15", result_id_o, result_data_o);
      end
      do_issue(3'b000, 5'd6, -32'sd2, 32'd4, 4'd3, 1'b1, 1'b0, a);
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mac_drain pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
      end
   endtask

   task automatic test_kill();
      logic a;
      bit   ok;
      int   n0;
      n0 = nres;
      do_issue(3'b010, 5'd7, 32'd1, 32'd1, 4'd1, 1'b0, 1'b0, a);
      do_issue(3'b010, 5'd8, 32'd2, 32'd2, 4'd2, 1'b0, 1'b0, a);
      do_commit(4'd1, 1'b1);
      do_commit(4'd2, 1'b0);
      drain(ok);
      checks++;
      if (!ok || nres - n0 != 1) begin
         errors++;
         $display("FAIL kill_count results=%0d pending=%0d, required 1 0", nres - n0, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic                       a;
      bit                         ok;
      int                         n;
      logic [IDW+5+32:0]          snap;
      exp_t                       e;
      result_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         do_issue(3'b010, 5'(i + 1), 32'(i), 32'(10 * i), 4'(4 + i), 1'b0, 1'b0, a);
      end
      checks++;
      if (issue_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_full ready=%b, required 0", issue_ready_o);
      end
      for (int i = 0; i < DEPTH; i++) do_commit(4'(4 + i), 1'b0);
      n = 0;
      while (!result_valid_o && n < 50) begin
         tick();
         n++;
      end
      e = exp_q[0];
      checks++;
      if (result_valid_o !== 1'b1 || result_id_o !== e.id || result_data_o !== e.data) begin
         errors++;
         $display("FAIL bp_first valid=%b id=%0d data=%0d, required 1 %0d %0d",
                  result_valid_o, result_id_o, result_data_o, e.id, e.data);
      end
      snap = {result_valid_o, result_id_o, result_rd_o, result_data_o};
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if ({result_valid_o, result_id_o, result_rd_o, result_data_o} !== snap) begin
            errors++;
            $display("FAIL bp_stable cycle=%0d got %h, required %h", c,
                     {result_valid_o, result_id_o, result_rd_o, result_data_o}, snap);
         end
      end
      result_ready_i = 1'b1;
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_drain pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
      end
   endtask

   task automatic test_saturation();
      logic a;
      bit   ok;
      do_issue(3'b001, 5'd9,  32'd0, 32'd0, 4'd8,  1'b1, 1'b0, a);
      do_issue(3'b000, 5'd10, 32'h7FFFFFF0, 32'd1, 4'd9, 1'b1, 1'b0, a);
      do_issue(3'b000, 5'd11, 32'd16, 32'd1, 4'd10, 1'b1, 1'b0, a);
      do_issue(3'b001, 5'd12, 32'd0, 32'd0, 4'd11, 1'b1, 1'b0, a);
      do_issue(3'b001, 5'd13, 32'd0, 32'd0, 4'd12, 1'b1, 1'b0, a);
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sat_drain pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
      end
   endtask

   task automatic test_reset_mid_exec();
      logic a;
      bit   ok;
      int   n0;
      do_issue(3'b000, 5'd1, 32'd7, 32'd7, 4'd13, 1'b1, 1'b0, a);
      tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      void'(exp_q.pop_back());
      pend_q.delete();
      acc_m = '0;
      checks++;
      if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec valid=%b busy=%b, required 0 0", result_valid_o, busy_o);
      end
      n0 = nres;
      repeat (8) tick();
      checks++;
      if (nres != n0 || result_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_result results=%0d valid=%b, required 0 0", nres - n0, result_valid_o);
      end
      do_issue(3'b000, 5'd2, 32'd2, 32'd2, 4'd14, 1'b1, 1'b0, a);
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_new_mac pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_reject();
      test_mac();
      test_kill();
      test_backpressure();
      test_saturation();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
